// File: rtl/kofn_window_detector.sv
// Per-sample k-of-n popcount threshold feeding a sliding window of hits;
// asserts a registered detect once the window hit count reaches a second threshold.
module kofn_window_detector #(
   parameter  int p_nbits = 3,
   parameter  int p_depth = 4,
   localparam int cw      = $clog2(p_nbits + 1),
   localparam int ww      = $clog2(p_depth + 1),
   localparam int fw      = $clog2(p_depth)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               in_val,
   input  logic [p_nbits-1:0] in,
   input  logic [cw-1:0]      thresh,
   input  logic [ww-1:0]      win_thresh,
   output logic [cw-1:0]      count,
   output logic               hit,
   output logic [ww-1:0]      win_count,
   output logic               full,
   output logic               out,
   output logic [7:0]         events
);

   localparam logic [1:0] st_empty = 2'd0;
   localparam logic [1:0] st_fill  = 2'd1;
   localparam logic [1:0] st_full  = 2'd2;

   logic [1:0]         state, state_next;
   logic [fw-1:0]      fill, fill_next;
   logic [p_depth-1:0] window, window_next;
   logic [ww-1:0]      win_count_next;
   logic               oldest;
   logic               out_next;

   always_comb begin
      count = '0;
      for (int i = 0; i < p_nbits; i++) begin
         count = count + cw'(in[i]);
      end
   end

   assign hit = in_val && (count >= thresh);

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
   always_comb begin
      state_next     = state;
      fill_next      = fill;
      window_next    = window;
      win_count_next = win_count;
      // Until the window has been filled, the bit falling off the end is reset filler, not a sample.
      oldest         = (state == st_full) && window[p_depth-1];
      if (in_val) begin
         window_next    = {window[p_depth-2:0], hit};
         win_count_next = win_count + ww'(hit) - ww'(oldest);
         case (state)
            st_empty: begin
               state_next = st_fill;
               fill_next  = fw'(1);
            end
            st_fill: begin
               fill_next = fill + fw'(1);
               // fill cannot hold p_depth itself, so test for the sample that would reach it.
               if (fill == fw'(p_depth - 1)) state_next = st_full;
            end
            default: ;
         endcase
      end
      out_next = (state_next == st_full) && (win_thresh != '0) && (win_count_next >= win_thresh);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state     <= st_empty;
         fill      <= '0;
         window    <= '0;
         win_count <= '0;
         out       <= 1'b0;
         events    <= '0;
      end else begin
         state     <= state_next;
         fill      <= fill_next;
         window    <= window_next;
         win_count <= win_count_next;
         out       <= out_next;
         if (out_next && !out && (events != 8'hff)) events <= events + 8'd1;
      end
   end

   assign full = (state == st_full);

endmodule

// File: tb/tb_kofn_window_detector.sv
// Scoreboard bench for kofn_window_detector: a history-queue reference model predicts
// every cycle's outputs; a monitor process pops and compares after each clock edge.
module tb_kofn_window_detector;

   localparam int p_nbits = 3;
   localparam int p_depth = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       in_val = 1'b0;
   logic [2:0] in = '0;
   logic [1:0] thresh = '0;
   logic [2:0] win_thresh = '0;
   logic [1:0] count;
   logic       hit;
   logic [2:0] win_count;
   logic       full;
   logic       out;
   logic [7:0] events;

   kofn_window_detector #(.p_nbits(p_nbits), .p_depth(p_depth)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_val(in_val), .in(in),
      .thresh(thresh), .win_thresh(win_thresh), .count(count), .hit(hit),
      .win_count(win_count), .full(full), .out(out), .events(events)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      bit hit;
      int wc;
      bit full;
      bit out;
      int ev;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the last p_depth valid hits, how many valid samples seen, out and events.
   bit   m_hist[$];
   int   m_nvalid = 0;
   bit   m_out = 0;
   int   m_events = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit r, input bit c, input bit v, input logic [2:0] i,
                       input logic [1:0] t, input logic [2:0] w);
      exp_t e;
      int   wc;
      bit   h, nf, no;
      @(negedge clk);
      rst = r; clear = c; in_val = v; in = i; thresh = t; win_thresh = w;
      e.cnt = $countones(i);
      h = v && (e.cnt >= int'(t));
      e.hit = h;
      if (r || c) begin
         m_hist.delete();
         m_nvalid = 0;
         m_out = 0;
         m_events = 0;
      end else if (v) begin
         m_hist.push_back(h);
         if (m_hist.size() > p_depth) void'(m_hist.pop_front());
         if (m_nvalid < p_depth) m_nvalid++;
      end
      wc = 0;
      foreach (m_hist[k]) wc += int'(m_hist[k]);
      nf = (m_nvalid >= p_depth);
      no = !(r || c) && nf && (w != 0) && (wc >= int'(w));
      if (no && !m_out && m_events < 255) m_events++;
      m_out = no;
      e.wc = wc;
      e.full = nf;
      e.out = no;
      e.ev = m_events;
      sb.push_back(e);
   endtask

   initial begin : monitor
      forever begin
         exp_t e;
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count", int'(count), e.cnt);
            check("hit", int'(hit), int'(e.hit));
            check("win_count", int'(win_count), e.wc);
            check("full", int'(full), int'(e.full));
            check("out", int'(out), int'(e.out));
            check("events", int'(events), e.ev);
         end
      end
   end

   initial begin : stimulus
      // Reset held two cycles while a full-ones sample is presented.
      step(1, 0, 1, 3'b111, 2'd2, 3'd2);
      step(1, 0, 1, 3'b111, 2'd2, 3'd2);
      // Popcount / per-sample hit, then clear back to empty.
      step(0, 0, 1, 3'b011, 2'd2, 3'd2);
      step(0, 0, 1, 3'b100, 2'd2, 3'd2);
      step(0, 0, 1, 3'b111, 2'd2, 3'd2);
      step(0, 0, 0, 3'b111, 2'd2, 3'd2);
      step(0, 0, 1, 3'b000, 2'd0, 3'd2);
      step(0, 1, 0, 3'b000, 2'd2, 3'd2);
      // Fill gating: hits 1,1,0,0.
      step(0, 0, 1, 3'b111, 2'd2, 3'd2);
      step(0, 0, 1, 3'b011, 2'd2, 3'd2);
      step(0, 0, 1, 3'b001, 2'd2, 3'd2);
      step(0, 0, 1, 3'b000, 2'd2, 3'd2);
      // Bubbles hold state, then slide.
      for (int k = 0; k < 3; k++) step(0, 0, 0, 3'b111, 2'd2, 3'd2);
      step(0, 0, 1, 3'b000, 2'd2, 3'd2);
      step(0, 0, 1, 3'b100, 2'd2, 3'd2);
      step(0, 0, 1, 3'b110, 2'd2, 3'd2);
      step(0, 0, 1, 3'b111, 2'd2, 3'd2);
      // Saturation: toggling win_thresh between 1 and 0 yields one rising edge per pair.
      for (int k = 0; k < 300; k++) begin
         step(0, 0, 0, 3'b000, 2'd2, 3'd1);
         step(0, 0, 0, 3'b000, 2'd2, 3'd0);
      end
      step(0, 0, 0, 3'b000, 2'd2, 3'd1);
      @(posedge clk);
      #2;
      check("events_saturated", int'(events), 255);
      // Reach FULL with win_count=3, out=1, then clear with a hitting sample.
      step(0, 0, 1, 3'b111, 2'd2, 3'd2);
      step(0, 1, 1, 3'b111, 2'd2, 3'd2);
      for (int k = 0; k < 4; k++) step(0, 0, 1, 3'b111, 2'd2, 3'd2);
      step(1, 1, 1, 3'b111, 2'd2, 3'd2);
      // Randomised traffic with rare clears/resets and varying thresholds.
      for (int k = 0; k < 1500; k++) begin
         logic [2:0] ri, rw;
         logic [1:0] rt;
         ri = 3'($urandom_range(0, 7));
         rt = 2'($urandom_range(0, 3));
         rw = 3'($urandom_range(0, 5));
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 63) == 0),
              ($urandom_range(0, 3) != 0), ri, rt, rw);
      end
      step(0, 0, 0, 3'b000, 2'd0, 3'd0);
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
      #3;
      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
